multiplier_array_stage: RTL and testbench
=========================================

# multiplier_array_stage

Weight-stationary multiplier array that produces the per-lane 32-bit partial products consumed by `Binary_Adder_Tree`. It holds one weight vector of `BREADTH_OF_TREE` signed weights, loaded in beats over a ready/valid port. It then multiplies each accepted activation vector lane-wise and presents the sign-extended products on a flat `32*BREADTH_OF_TREE` bus wired directly to the tree's `din`.

## Interface
Parameters:
- `DATA_BITWIDTH`, 8: width of one activation and of one weight; requires `2*DATA_BITWIDTH+1 <= 32`.
- `BREADTH_OF_TREE`, 32: number of lanes; must equal the adder tree's breadth.
- `WEIGHTS_PER_BEAT`, 4: weights per load beat; must divide `BREADTH_OF_TREE`.

Ports:
- Reset is asynchronous and active-low; one clock.
- `clk`, input, 1: clock.
- `rstN`, input, 1: asynchronous active-low reset.
- `load_start`, input, 1: single-cycle request to (re)load the weight vector.
- `w_valid`, input, 1: weight beat valid.
- `w_ready`, output, 1: weight beat accepted when `w_valid && w_ready`.
- `w_data`, input, `WEIGHTS_PER_BEAT*DATA_BITWIDTH`: signed weights; lane `j` of the beat sits at `[j*DATA_BITWIDTH +: DATA_BITWIDTH]`.
- `a_valid`, input, 1: activation vector valid.
- `a_ready`, output, 1: activation vector accepted when `a_valid && a_ready`.
- `a_data`, input, `BREADTH_OF_TREE*DATA_BITWIDTH`: unsigned activations, lane `i` at `[i*DATA_BITWIDTH +: DATA_BITWIDTH]`.
- `dout`, output, `32*BREADTH_OF_TREE`: products, lane `i` at `[i*32 +: 32]`.
- `dout_valid`, output, 1: `dout` holds the products of one accepted vector.
- `weights_loaded`, output, 1: high while in RUN.

## Operation
- States: IDLE, LOAD and RUN. Reset enters IDLE.
- IDLE:
  - `w_ready=0`, `a_ready=0`.
  - `load_start` moves the block to LOAD with the beat counter cleared to 0.
- LOAD:
  - `w_ready=1`, `a_ready=0`.
  - An accepted beat `b` writes weight lanes `b*WEIGHTS_PER_BEAT .. b*WEIGHTS_PER_BEAT+WEIGHTS_PER_BEAT-1`, then increments the counter.
  - Acceptance of beat `BREADTH_OF_TREE/WEIGHTS_PER_BEAT-1` moves the block to RUN.
  - `load_start` in LOAD restarts the counter at 0. A beat accepted in that same cycle is still written at the old count.
- RUN:
  - `w_ready=0`, `a_ready=1`.
  - `load_start` moves the block to LOAD with the counter at 0. An activation accepted in that same cycle is processed normally.
- The weight bank is never cleared, including on reset. Bank contents are defined only after the first complete load.
- Arithmetic, per lane: `$signed(weight) * $signed({1'b0, act})`.
  - The result is `2*DATA_BITWIDTH+1` bits, sign-extended to 32 bits.
  - No saturation.
- Bubble rule:
  - The adder tree has no valid input.
  - In any cycle where `dout_valid=0`, `dout` is all zeros, so that bubbles sum to 0.
- No backpressure from downstream: results are never stalled.
- Reset values:
  - `dout=0`, `dout_valid=0`, `w_ready=0`, `a_ready=0`, `weights_loaded=0`.
  - Beat counter = 0.
  - Pipeline valid bits = 0.
- Reset mid-operation:
  - In-flight products are discarded and outputs return to reset values at once.
  - A new `load_start` is required after reset.

## Timing
- Two-stage pipeline.
  - Stage 1 registers the accepted activations and a valid bit at edge k.
  - Stage 2 registers the products at edge k+1. It uses the weight bank value before that edge.
- `dout` and `dout_valid` are therefore valid in the cycle after edge k+1, i.e. latency 2.
- Throughput is one vector per cycle in RUN.
- Reload hazard:
  - The first new weight beat can be written at edge k+1 at the earliest.
  - Because stage 2 samples the pre-edge bank, vectors accepted before the LOAD transition always use the old weights.
- Loading takes exactly `BREADTH_OF_TREE/WEIGHTS_PER_BEAT` accepted beats. `a_ready` rises the cycle after the last beat is accepted.
- `weights_loaded` equals `(state==RUN)`, registered.

## Structure
- Shared package holds:
  - `PSUM_WIDTH = 32`;
  - the state encoding (IDLE/LOAD/RUN);
  - the beat-count width function.
- Sub-module `mult_lane` performs one signed×unsigned multiply with sign extension to `PSUM_WIDTH`. It is generated `BREADTH_OF_TREE` times.
- The FSM, counter, weight bank and pipeline registers live in the top module.

## Test plan
- Reset then load:
  - Stimulus: `load_start`, then 8 beats with weights 1..32 and `w_valid` held high.
  - Required: `w_ready` high for 8 cycles, `a_ready` rises the next cycle, `weights_loaded=1`.
- Signed product:
  - Stimulus: weight lane 0 = -128 (0x80), act lane 0 = 255.
  - Required: `dout[31:0] = 0xFFFF8080` (-32640) two cycles after acceptance; other lanes equal `w_i*act_i`.
- Streaming with a gap:
  - Stimulus: vectors accepted at cycles 0, 1 and 3.
  - Required: `dout_valid` high at cycles 2, 3 and 5, and low at cycle 4 with `dout = 0`.
- Reload race:
  - Stimulus: `a_valid` and `load_start` in the same RUN cycle, then new weights all = 2.
  - Required: that vector's products use the old weights; `a_ready=0` until the last new beat is accepted; the next vector with all activations = 3 yields 6 in every lane.
- Restart in LOAD:
  - Stimulus: `load_start` after 3 beats, then 8 fresh beats.
  - Required: RUN is entered only after the 8th fresh beat, and the bank holds the fresh weights.
- Async reset mid-stream:
  - Stimulus: `rstN` asserted low between clock edges while `dout_valid=1`.
  - Required: `dout=0`, `dout_valid=0` and `a_ready=0` immediately; the block stays in IDLE until `load_start`.

Source files
------------

// File: rtl/multiplier_array_stage_pkg.sv
// Shared definitions for the weight-stationary multiplier array feeding the adder tree.
package multiplier_array_stage_pkg;

   localparam int unsigned PSUM_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   function automatic int unsigned beat_cnt_width(input int unsigned num_beats);
      return (num_beats > 1) ? $clog2(num_beats) : 1;
   endfunction

endpackage

// File: rtl/multiplier_array_stage_mult_lane.sv
// One lane: signed weight times unsigned activation, sign-extended to the partial-sum width.
module mult_lane
   import multiplier_array_stage_pkg::*;
#(
   parameter int unsigned DATA_BITWIDTH = 8
) (
   input  logic [DATA_BITWIDTH-1:0] i_weight,
   input  logic [DATA_BITWIDTH-1:0] i_act,
   output logic [PSUM_WIDTH-1:0]    o_prod_c
);

   localparam int unsigned PROD_W = 2 * DATA_BITWIDTH + 1;

   logic signed [PROD_W-1:0] w_prod;

   // Zero-extending the activation keeps it non-negative inside the signed multiply.
   assign w_prod   = PROD_W'($signed(i_weight)) * PROD_W'($signed({1'b0, i_act}));
   assign o_prod_c = PSUM_WIDTH'(w_prod);

endmodule

// File: rtl/multiplier_array_stage.sv
// Weight-stationary multiplier array: beat-loaded weight bank, two-stage product pipeline
// whose zeroed bubbles let the downstream adder tree run without a valid input.
module multiplier_array_stage
   import multiplier_array_stage_pkg::*;
#(
   parameter int unsigned DATA_BITWIDTH    = 8,
   parameter int unsigned BREADTH_OF_TREE  = 32,
   parameter int unsigned WEIGHTS_PER_BEAT = 4
) (
   input  logic                                    clk,
   input  logic                                    rstN,
   input  logic                                    load_start,
   input  logic                                    w_valid,
   output logic                                    w_ready,
   input  logic [WEIGHTS_PER_BEAT*DATA_BITWIDTH-1:0] w_data,
   input  logic                                    a_valid,
   output logic                                    a_ready,
   input  logic [BREADTH_OF_TREE*DATA_BITWIDTH-1:0]  a_data,
   output logic [PSUM_WIDTH*BREADTH_OF_TREE-1:0]     dout,
   output logic                                    dout_valid,
   output logic                                    weights_loaded
);

   localparam int unsigned NUM_BEATS = BREADTH_OF_TREE / WEIGHTS_PER_BEAT;
   localparam int unsigned CNT_W     = beat_cnt_width(NUM_BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   state_t                                   r_state;
   logic [CNT_W-1:0]                         r_cnt;
   logic                                     r_w_ready;
   logic                                     r_a_ready;
   logic                                     r_loaded;
   logic                                     r_s1_valid;
   logic [BREADTH_OF_TREE*DATA_BITWIDTH-1:0] r_s1_act;
   logic [PSUM_WIDTH*BREADTH_OF_TREE-1:0]    r_dout;
   logic                                     r_dout_valid;
   logic [PSUM_WIDTH*BREADTH_OF_TREE-1:0]    w_prod;
   logic                                     w_w_acc;
   logic                                     w_a_acc;

   assign w_w_acc = w_valid && r_w_ready;
   assign w_a_acc = a_valid && r_a_ready;

   // Control FSM; handshake outputs are registered alongside the state they reflect.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_w_ready <= 1'b0;
         r_a_ready <= 1'b0;
         r_loaded  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load_start) begin
                  r_state   <= ST_LOAD;
                  r_cnt     <= '0;
                  r_w_ready <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (load_start) begin
                  r_cnt <= '0;
               end else if (w_w_acc) begin
                  if (r_cnt == LAST_BEAT) begin
                     r_state   <= ST_RUN;
                     r_cnt     <= '0;
                     r_w_ready <= 1'b0;
                     r_a_ready <= 1'b1;
                     r_loaded  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (load_start) begin
                  r_state   <= ST_LOAD;
                  r_cnt     <= '0;
                  r_w_ready <= 1'b1;
                  r_a_ready <= 1'b0;
                  r_loaded  <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_cnt     <= '0;
               r_w_ready <= 1'b0;
               r_a_ready <= 1'b0;
               r_loaded  <= 1'b0;
            end
         endcase
      end
   end

   // Per-lane weight register (deliberately not reset) and multiplier.
   for (genvar i = 0; i < BREADTH_OF_TREE; i++) begin : g_lane
      localparam logic [CNT_W-1:0] BEAT = CNT_W'(i / WEIGHTS_PER_BEAT);
      localparam int unsigned      SLOT = i % WEIGHTS_PER_BEAT;

      logic [DATA_BITWIDTH-1:0] r_weight;

      always_ff @(posedge clk) begin
         if (w_w_acc && (r_cnt == BEAT)) begin
            r_weight <= w_data[SLOT*DATA_BITWIDTH +: DATA_BITWIDTH];
         end
      end

      mult_lane #(
         .DATA_BITWIDTH(DATA_BITWIDTH)
      ) u_mult_lane (
         .i_weight (r_weight),
         .i_act    (r_s1_act[i*DATA_BITWIDTH +: DATA_BITWIDTH]),
         .o_prod_c (w_prod[i*PSUM_WIDTH +: PSUM_WIDTH])
      );
   end

   always_ff @(posedge clk) begin
      if (w_a_acc) begin
         r_s1_act <= a_data;
      end
   end

   // Stage 1 valid and stage 2 products; bubbles present all-zero data.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_s1_valid   <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_s1_valid   <= w_a_acc;
         r_dout_valid <= r_s1_valid;
         r_dout       <= r_s1_valid ? w_prod : '0;
      end
   end

   assign w_ready        = r_w_ready;
   assign a_ready        = r_a_ready;
   assign weights_loaded = r_loaded;
   assign dout           = r_dout;
   assign dout_valid     = r_dout_valid;

endmodule

// File: tb/tb_multiplier_array_stage.sv
// Self-checking bench: table-driven product checks, directed corner sequences and a
// randomized run, all scored against a transaction-level model of the array.
module tb_multiplier_array_stage;

   localparam int DW = 8;
   localparam int NL = 32;
   localparam int WPB = 4;
   localparam int NB = NL / WPB;

   logic               clk = 1'b0;
   logic               rstN;
   logic               load_start;
   logic               w_valid;
   logic               w_ready;
   logic [WPB*DW-1:0]  w_data;
   logic               a_valid;
   logic               a_ready;
   logic [NL*DW-1:0]   a_data;
   logic [32*NL-1:0]   dout;
   logic               dout_valid;
   logic               weights_loaded;

   multiplier_array_stage #(
      .DATA_BITWIDTH    (DW),
      .BREADTH_OF_TREE  (NL),
      .WEIGHTS_PER_BEAT (WPB)
   ) dut (
      .clk            (clk),
      .rstN           (rstN),
      .load_start     (load_start),
      .w_valid        (w_valid),
      .w_ready        (w_ready),
      .w_data         (w_data),
      .a_valid        (a_valid),
      .a_ready        (a_ready),
      .a_data         (a_data),
      .dout           (dout),
      .dout_valid     (dout_valid),
      .weights_loaded (weights_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               due;
      logic [32*NL-1:0] prod;
   } exp_t;

   typedef struct {
      logic [7:0]  w;
      logic [7:0]  a;
      logic [31:0] exp;
   } vec_t;

   // Model: phase 0 idle, 1 loading, 2 running.
   int   m_phase;
   int   m_beat;
   int   m_w [NL];
   exp_t q [$];
   int   cyc;
   int   n_tests;
   int   n_fail;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic chk_dout(input string name, input logic [32*NL-1:0] exp);
      n_tests++;
      for (int i = 0; i < NL; i++) begin
         if (dout[i*32 +: 32] !== exp[i*32 +: 32]) begin
            n_fail++;
            $display("FAIL %s at cycle %0d lane %0d: got %h expected %h",
                     name, cyc, i, dout[i*32 +: 32], exp[i*32 +: 32]);
            break;
         end
      end
   endtask

   function automatic logic [32*NL-1:0] model_products(input logic [NL*DW-1:0] acts);
      logic [32*NL-1:0] r;
      for (int i = 0; i < NL; i++) begin
         int a;
         a = int'(acts[i*DW +: DW]);
         r[i*32 +: 32] = 32'(m_w[i] * a);
      end
      return r;
   endfunction

   task automatic check_outputs();
      logic exp_v;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("w_ready", 32'(w_ready), 32'(m_phase == 1));
      chk("a_ready", 32'(a_ready), 32'(m_phase == 2));
      chk("weights_loaded", 32'(weights_loaded), 32'(m_phase == 2));
      chk("dout_valid", 32'(dout_valid), 32'(exp_v));
      if (exp_v) begin
         chk_dout("dout", q[0].prod);
         void'(q.pop_front());
      end else begin
         chk_dout("dout_bubble", '0);
      end
   endtask

   task automatic cycle(input logic ls, input logic wv, input logic [WPB*DW-1:0] wd,
                        input logic av, input logic [NL*DW-1:0] ad);
      logic acc_a, acc_w;
      exp_t e;
      load_start = ls; w_valid = wv; w_data = wd; a_valid = av; a_data = ad;
      acc_a = rstN && av && (m_phase == 2);
      acc_w = rstN && wv && (m_phase == 1);
      if (acc_a) e.prod = model_products(ad);
      @(posedge clk);
      #1;
      cyc++;
      if (!rstN) begin
         m_phase = 0;
         m_beat  = 0;
         q.delete();
      end else begin
         if (acc_a) begin
            e.due = cyc + 1;
            q.push_back(e);
         end
         case (m_phase)
            0: if (ls) begin m_phase = 1; m_beat = 0; end
            1: begin
               if (acc_w)
                  for (int j = 0; j < WPB; j++) m_w[m_beat*WPB + j] = int'($signed(wd[j*DW +: DW]));
               if (ls) m_beat = 0;
               else if (acc_w) begin
                  if (m_beat == NB - 1) m_phase = 2;
                  else m_beat++;
               end
            end
            default: if (ls) begin m_phase = 1; m_beat = 0; end
         endcase
      end
      check_outputs();
      load_start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
   endtask

   function automatic logic [NL*DW-1:0] rand_acts();
      logic [NL*DW-1:0] r;
      for (int k = 0; k < NL*DW/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   // Load a full weight vector: load_start cycle followed by NB back-to-back beats.
   task automatic load_weights(input logic [NL*DW-1:0] wv);
      cycle(1'b1, 1'b0, '0, 1'b0, '0);
      for (int b = 0; b < NB; b++) cycle(1'b0, 1'b1, wv[b*WPB*DW +: WPB*DW], 1'b0, '0);
   endtask

   vec_t             tbl [12];
   logic [NL*DW-1:0] wvec;
   logic [NL*DW-1:0] avec;

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0;
      m_phase = 0; m_beat = 0;
      for (int i = 0; i < NL; i++) m_w[i] = 0;
      rstN = 1'b0; load_start = 1'b0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_w_ready", 32'(w_ready), 32'd0);
      chk("rst_loaded", 32'(weights_loaded), 32'd0);
      chk_dout("rst_dout", '0);
      rstN = 1'b1;
      idle(2);

      // Load weights 1..32 and stream one vector
      for (int i = 0; i < NL; i++) wvec[i*DW +: DW] = 8'(i + 1);
      load_weights(wvec);
      chk("load_a_ready", 32'(a_ready), 32'd1);
      chk("load_loaded", 32'(weights_loaded), 32'd1);
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      idle(3);

      // Table-driven signed x unsigned products
      tbl[0]  = '{8'h80, 8'hFF, 32'hFFFF8080};
      tbl[1]  = '{8'h7F, 8'hFF, 32'h00007E81};
      tbl[2]  = '{8'hFF, 8'h00, 32'h00000000};
      tbl[3]  = '{8'hFF, 8'h01, 32'hFFFFFFFF};
      tbl[4]  = '{8'h00, 8'hC8, 32'h00000000};
      tbl[5]  = '{8'h01, 8'hFF, 32'h000000FF};
      tbl[6]  = '{8'h80, 8'h00, 32'h00000000};
      tbl[7]  = '{8'h7F, 8'h01, 32'h0000007F};
      tbl[8]  = '{8'h80, 8'h01, 32'hFFFFFF80};
      tbl[9]  = '{8'h40, 8'h02, 32'h00000080};
      tbl[10] = '{8'hFE, 8'h64, 32'hFFFFFF38};
      tbl[11] = '{8'hFF, 8'hFF, 32'hFFFFFF01};
      wvec = '0;
      avec = rand_acts();
      for (int i = 0; i < 12; i++) begin
         wvec[i*DW +: DW] = tbl[i].w;
         avec[i*DW +: DW] = tbl[i].a;
      end
      load_weights(wvec);
      cycle(1'b0, 1'b0, '0, 1'b1, avec);
      cycle(1'b0, 1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 12; i++) chk($sformatf("tbl_lane%0d", i), dout[i*32 +: 32], tbl[i].exp);
      idle(2);

      // Streaming with a gap: accepts at 0,1,3 -> bubble in between
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      cycle(1'b0, 1'b0, '0, 1'b0, '0);
      chk("gap_v1", 32'(dout_valid), 32'd1);
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      chk("gap_bubble_valid", 32'(dout_valid), 32'd0);
      chk_dout("gap_bubble_dout", '0);
      cycle(1'b0, 1'b0, '0, 1'b0, '0);
      chk("gap_v3", 32'(dout_valid), 32'd1);
      idle(2);

      // Reload race: vector and load_start together, then weights all 2
      cycle(1'b1, 1'b0, '0, 1'b1, rand_acts());
      for (int b = 0; b < NB; b++) begin
         chk("race_a_ready_low", 32'(a_ready), 32'd0);
         cycle(1'b0, 1'b1, 32'h02020202, 1'b1, rand_acts());
      end
      chk("race_a_ready_high", 32'(a_ready), 32'd1);
      for (int i = 0; i < NL; i++) avec[i*DW +: DW] = 8'd3;
      cycle(1'b0, 1'b0, '0, 1'b1, avec);
      cycle(1'b0, 1'b0, '0, 1'b0, '0);
      for (int i = 0; i < NL; i += 7) chk($sformatf("race_six_lane%0d", i), dout[i*32 +: 32], 32'd6);
      idle(2);

      // Restart in LOAD after 3 beats, then 8 fresh beats
      cycle(1'b1, 1'b0, '0, 1'b0, '0);
      for (int b = 0; b < 3; b++) cycle(1'b0, 1'b1, $urandom, 1'b0, '0);
      cycle(1'b1, 1'b0, '0, 1'b0, '0);
      for (int b = 0; b < NB; b++) begin
         chk("restart_not_run", 32'(weights_loaded), 32'd0);
         cycle(1'b0, 1'b1, $urandom, 1'b0, '0);
      end
      chk("restart_run", 32'(weights_loaded), 32'd1);
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      idle(3);

      // Randomized run with occasional reloads
      for (int k = 0; k < 300; k++) begin
         logic ls;
         ls = ($urandom_range(0, 39) == 0);
         cycle(ls, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), rand_acts());
      end
      for (int k = 0; k < 20 && m_phase != 2; k++) cycle(1'b0, 1'b1, $urandom, 1'b0, '0);
      if (m_phase != 2) load_weights(rand_acts());

      // Async reset between edges while results are streaming
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      chk("pre_rst_valid", 32'(dout_valid), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      chk("async_rst_valid", 32'(dout_valid), 32'd0);
      chk("async_rst_a_ready", 32'(a_ready), 32'd0);
      chk_dout("async_rst_dout", '0);
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      rstN = 1'b1;
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, $urandom, 1'b1, rand_acts());
      chk("post_rst_idle", 32'(weights_loaded), 32'd0);
      load_weights(rand_acts());
      cycle(1'b0, 1'b0, '0, 1'b1, rand_acts());
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
